vram_fill_engine: RTL and testbench
===================================

# vram_fill_engine

Parametrised VRAM fill sequencer on the VRAM write port (port A), clocked by MEMORY_CLK. It writes a contiguous, wrapping address region with one of three data patterns: constant, masked increment, or address-derived. Each fill is started by a single-cycle `start` strobe and ends with a `done` pulse. The block replaces the fixed power-on VRAM test-pattern writer. The power-on fill is kept as a compile-time option.

## Interface
- `ADDR_W`, default 10: VRAM address width. Region arithmetic is modulo 2^ADDR_W.
- `DATA_W`, default 8: VRAM data width.
- `PAT_MASK`, default 'h7F (DATA_W bits): mask applied to INC and ADDR pattern data.

- `MEMORY_CLK`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `start`, input, 1: fill request. Sampled only in IDLE.
- `mode`, input, 2: pattern select, sampled with `start`. 0 = CONST, 1 = INC, 2 = ADDR, 3 = treated as CONST.
- `base`, input, ADDR_W: first address, sampled with `start`.
- `len`, input, ADDR_W+1: number of writes, sampled with `start`. Range 0..2^ADDR_W.
- `value`, input, DATA_W: CONST data, or INC seed. Sampled with `start`.
- `pause`, input, 1: holds the fill between writes. Level-sensitive.
- `busy`, output, 1: high while a fill is in progress, including the DONE cycle.
- `done`, output, 1: single-cycle completion pulse.
- `v_ada`, output, ADDR_W: VRAM write address.
- `v_din`, output, DATA_W: VRAM write data.
- `v_cea`, output, 1: VRAM write enable. Registered.

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `v_cea`=0, `v_ada`=0, `v_din`=0. State = IDLE. Remaining count = 0.
- States: IDLE, WRITE, ADVANCE, DONE.
- IDLE:
  - `start`=1 and `len`≠0: latch inputs; set `v_ada`=`base`, set `v_din`=first datum, set remaining=`len`; go to WRITE.
  - `start`=1 and `len`=0: go to DONE with no write.
- WRITE: `v_cea`=1 for exactly one cycle; go to ADVANCE unconditionally.
- ADVANCE: `v_cea`=0.
  - remaining==1: go to DONE.
  - else if `pause`=1: hold ADVANCE, with all outputs unchanged.
  - else: `v_ada`←(`v_ada`+1) mod 2^ADDR_W; compute the next datum; remaining−1; go to WRITE.
- DONE: `done`=1 and `busy`=1 for one cycle; then go to IDLE, where `busy`=0.
- Data patterns:
  - CONST: `v_din`=`value` on every write.
  - INC: the first datum is `value`&PAT_MASK; each next datum is (prev+1)&PAT_MASK, computed at DATA_W width.
  - ADDR: `v_din`=zero-extended/truncated `v_ada`[DATA_W-1:0]&PAT_MASK for the address being written.
- Boundary conditions:
  - `start` is ignored outside IDLE; no queueing.
  - An address wrap at 2^ADDR_W−1 → 0 is legal.
  - `len`=2^ADDR_W writes every location exactly once.
  - `pause` never truncates a `v_cea` pulse already issued; it only delays the next one.
  - Asserting `rst_n`=0 mid-fill aborts immediately: all outputs take their reset values and the region is left partially written.
- `mode`, `base`, `len` and `value` may change freely while `busy`=1 without any effect on the fill in progress.

## Timing
- Take the `start` sampling edge as cycle 0.
- Write k (0-based) has `v_cea`=1 in cycle 2k+1.
- `done`=1 in cycle 2·len+1, and `busy` falls in cycle 2·len+2. With `len`=0, `done` is in cycle 1.
- Throughput is 1 write per 2 cycles. Each cycle of pause in ADVANCE adds exactly 1 cycle.
- `v_ada` and `v_din` are stable throughout every cycle in which `v_cea`=1. They change only in ADVANCE→WRITE transitions or at the IDLE latch.

## Configuration
- `VRAM_FILL_BOOT_EN`, defined: on the first edge after `rst_n` rises, the block self-starts a fill with mode=INC, base=0, len=2^ADDR_W, value=0. This produces the power-on test pattern addr&PAT_MASK.
  - `start` is ignored until its `done`.
  - `busy`=1 from cycle 1 after reset release.
  - `done` pulses at cycle 2·2^ADDR_W+1.
- `VRAM_FILL_BOOT_EN`, undefined: the block stays in IDLE after reset until `start`.

## Test plan
- CONST wrap: `base`=0x3FE, `len`=4, `value`=0xA5 → writes 0xA5 to 0x3FE, 0x3FF, 0x000, 0x001 in cycles 1, 3, 5, 7; `done` in cycle 9; `busy` low in cycle 10.
- INC mask: mode=1, `value`=0x7E, `len`=3, PAT_MASK=0x7F → data 0x7E, 0x7F, 0x00 at `base`, `base`+1, `base`+2.
- Zero length: `len`=0 → `done` in cycle 1; `v_cea` never 1; `busy` high only in cycle 1.
- Pause: `len`=3, `pause`=1 for 5 cycles starting in the cycle after the first write → no `v_cea` during the pause; writes 2 and 3 follow; `done` in cycle 12.
- Busy/reset: `start` re-pulsed while busy → ignored, write count unchanged. `rst_n` low after write 2 of 8 → all outputs 0 asynchronously, and no further writes after release.
- Boot (`VRAM_FILL_BOOT_EN`, ADDR_W=10): release reset → 1024 writes, each with data addr&0x7F; `done` at cycle 2049; a `start` during boot is ignored.

Source files
------------

// File: rtl/vram_fill_engine_if.sv
// Fill-engine request/VRAM write bundle.
//
// Handshake: `start` is a one-cycle request. It is taken only while the engine
// is idle (busy=0), and mode/base/len/value are sampled on that same edge.
// There is no ready signal and no queueing. A start seen while busy=1 is
// dropped. `done` pulses for one cycle at the end of every accepted request,
// including zero-length ones. v_cea/v_ada/v_din form the VRAM port-A write:
// one write per cycle in which v_cea=1.
interface vram_fill_engine_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              start;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   len;
   logic [DATA_W-1:0] value;
   logic              pause;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] v_ada;
   logic [DATA_W-1:0] v_din;
   logic              v_cea;

   // Requester side (controller / testbench).
   modport master (
      output start, mode, base, len, value, pause,
      input  busy, done, v_ada, v_din, v_cea
   );

   // Engine side.
   modport slave (
      input  start, mode, base, len, value, pause,
      output busy, done, v_ada, v_din, v_cea
   );
endinterface

// File: rtl/vram_fill_engine.sv
// VRAM fill sequencer. It writes a wrapping address region on port A with
// CONST, masked INC or ADDR-derived data, one write every two cycles.
// Optional macro VRAM_FILL_BOOT_EN: self-start an INC fill of the whole VRAM
// (base 0, seed 0) on the first edge after reset release. This fill is the
// power-on test pattern.
// All outputs are registered from the next-state values. An output therefore
// belongs to the state the FSM is in during that same cycle.
module vram_fill_engine #(
   parameter int                ADDR_W   = 10,
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] PAT_MASK = 'h7F
) (
   input  logic              MEMORY_CLK,
   input  logic              rst_n,
   vram_fill_engine_if.slave bus,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_ADVANCE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [1:0]        MODE_INC  = 2'd1;
   localparam logic [1:0]        MODE_ADDR = 2'd2;
   localparam logic [ADDR_W-1:0] ADA_ONE   = ADDR_W'(1);
   localparam logic [DATA_W-1:0] DIN_ONE   = DATA_W'(1);
   localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W-1:0] ada_d;
   logic [DATA_W-1:0] din_d;

   // Launch request as seen by IDLE: either the external start or the boot fill.
   logic              go;
   logic [1:0]        l_mode;
   logic [ADDR_W-1:0] l_base;
   logic [ADDR_W:0]   l_len;
   logic [DATA_W-1:0] l_value;

   // ADDR pattern: low DATA_W bits of the address (zero-extended if narrower), masked.
   function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) & PAT_MASK;
   endfunction

`ifdef VRAM_FILL_BOOT_EN
   localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

   logic boot_q;

   // Boot request stays armed from reset until the first idle edge consumes it.
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n)                boot_q <= 1'b1;
      else if (state_q == S_IDLE) boot_q <= 1'b0;
   end

   // The boot fill overrides the external request. Any start in that cycle is dropped.
   always_comb begin
      go      = bus.start;
      l_mode  = bus.mode;
      l_base  = bus.base;
      l_len   = bus.len;
      l_value = bus.value;
      if (boot_q) begin
         go      = 1'b1;
         l_mode  = MODE_INC;
         l_base  = '0;
         l_len   = LEN_FULL;
         l_value = '0;
      end
   end
`else
   // Without boot fill the only launch source is the external start.
   always_comb begin
      go      = bus.start;
      l_mode  = bus.mode;
      l_base  = bus.base;
      l_len   = bus.len;
      l_value = bus.value;
   end
`endif

   // Next-state and next-output logic for the fill sequence.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      ada_d   = bus.v_ada;
      din_d   = bus.v_din;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (l_len != '0) begin
                  mode_d  = l_mode;
                  ada_d   = l_base;
                  rem_d   = l_len;
                  state_d = S_WRITE;
                  case (l_mode)
                     MODE_INC:  din_d = l_value & PAT_MASK;
                     MODE_ADDR: din_d = addr_pattern(l_base);
                     default:   din_d = l_value;
                  endcase
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WRITE: begin
            state_d = S_ADVANCE;
         end
         S_ADVANCE: begin
            // The last write finishes the fill even under pause.
            if (rem_q == REM_ONE) begin
               rem_d   = '0;
               state_d = S_DONE;
            end else if (!bus.pause) begin
               ada_d   = bus.v_ada + ADA_ONE;
               rem_d   = rem_q - REM_ONE;
               state_d = S_WRITE;
               case (mode_q)
                  MODE_INC:  din_d = (bus.v_din + DIN_ONE) & PAT_MASK;
                  MODE_ADDR: din_d = addr_pattern(ada_d);
                  default:   din_d = bus.v_din;
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, latched mode/count and registered VRAM port outputs. Reset aborts immediately.
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         rem_q     <= '0;
         bus.v_ada <= '0;
         bus.v_din <= '0;
         bus.v_cea <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         rem_q     <= rem_d;
         bus.v_ada <= ada_d;
         bus.v_din <= din_d;
         bus.v_cea <= (state_d == S_WRITE);
         bus.busy  <= (state_d != S_IDLE);
         bus.done  <= (state_d == S_DONE);
      end
   end

   assign fsm_state = state_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Bench for vram_fill_engine. A reference model turns each fill request into
// the list of writes it should produce (absolute cycle, address, data) plus
// the cycle of its done pulse. A monitor pops and compares these as the DUT
// presents v_cea / done.
module tb_vram_fill_engine;
   localparam int            AW = 10;
   localparam int            DW = 8;
   localparam logic [DW-1:0] M  = 8'h7F;
   localparam int            WW = 32 + AW + DW;

   logic       MEMORY_CLK = 1'b0;
   logic       rst_n      = 1'b0;
   logic [1:0] fsm_state;

   always #5 MEMORY_CLK = ~MEMORY_CLK;

   vram_fill_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .PAT_MASK(M)) dut (
      .MEMORY_CLK (MEMORY_CLK),
      .rst_n      (rst_n),
      .bus        (bus),
      .fsm_state  (fsm_state)
   );

   // cyc = number of rising edges so far. Values seen at a negedge are the
   // ones sampled at edge cyc+1.
   int cyc = 0;
   always @(posedge MEMORY_CLK) cyc <= cyc + 1;

   logic [WW-1:0] exp_q[$];
   int            done_q[$];
   int            total = 0;
   int            bad   = 0;
   logic          prev_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc + 1);
      end
   endtask

   // Reference model. Write k of a fill started at edge s comes two cycles after
   // the previous one. Each pause cycle seen between writes adds one cycle.
   // Pause has no effect once the last write has gone out.
   task automatic push_fill(input int mode, input logic [AW-1:0] base, input int len,
                            input logic [DW-1:0] value, input int s, input int pw0,
                            input int pwl, output int dcyc);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            t;
      int            adv;
      a = base;
      t = s + 1;
      d = (mode == 1) ? (value & M) : (mode == 2) ? (DW'(a) & M) : value;
      for (int k = 0; k < len; k++) begin
         if (k > 0) begin
            adv = t + 1;
            while (adv >= s + pw0 && adv < s + pw0 + pwl) adv++;
            t = adv + 1;
            a = a + AW'(1);
            d = (mode == 1) ? ((d + DW'(1)) & M) : (mode == 2) ? (DW'(a) & M) : value;
         end
         exp_q.push_back({32'(t), a, d});
      end
      dcyc = (len == 0) ? s + 1 : t + 2;
      done_q.push_back(dcyc);
   endtask

   // Monitor: compare every write and done pulse against the scoreboard.
   always @(negedge MEMORY_CLK) begin
      int            now;
      logic [WW-1:0] e;
      if (rst_n) begin
         now = cyc + 1;
         if (prev_done) check("busy_after_done", 64'(bus.busy), 64'd0);
         prev_done = bus.done;
         if (bus.v_cea) begin
            check("write_busy", 64'(bus.busy), 64'd1);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_write: got addr %0h data %0h expected no write", bus.v_ada, bus.v_din);
            end else begin
               e = exp_q.pop_front();
               check("write_cycle", 64'(now), 64'(e[WW-1 -: 32]));
               check("write_addr", 64'(bus.v_ada), 64'(e[AW+DW-1:DW]));
               check("write_data", 64'(bus.v_din), 64'(e[DW-1:0]));
            end
         end
         if (bus.done) begin
            check("done_busy", 64'(bus.busy), 64'd1);
            check("done_no_write", 64'(bus.v_cea), 64'd0);
            if (done_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done at edge %0d expected none", now);
            end else begin
               check("done_cycle", 64'(now), 64'(done_q.pop_front()));
            end
         end
      end else begin
         prev_done = 1'b0;
      end
   end

   // Drive pause and junk traffic until one cycle past the expected done.
   task automatic drive(input int s, input int dcyc, input int pw0, input int pwl, input int junk_rel);
      int rel;
      for (int i = 0; i < dcyc - s + 4; i++) begin
         @(negedge MEMORY_CLK);
         rel = cyc + 1 - s;
         if (rel > dcyc - s) break;
         bus.start = (rel == junk_rel);
         bus.pause = (rel >= pw0) && (rel < pw0 + pwl);
         bus.mode  = 2'($urandom_range(0, 3));
         bus.base  = AW'($urandom);
         bus.len   = (AW+1)'($urandom_range(0, 1 << AW));
         bus.value = DW'($urandom);
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      check("drained_writes", 64'(exp_q.size()), 64'd0);
      check("drained_done", 64'(done_q.size()), 64'd0);
   endtask

   task automatic run_fill(input int mode, input logic [AW-1:0] base, input int len,
                           input logic [DW-1:0] value, input int pw0, input int pwl,
                           input bit junk);
      int s;
      int dcyc;
      @(negedge MEMORY_CLK);
      bus.start = 1'b1;
      bus.mode  = 2'(mode);
      bus.base  = base;
      bus.len   = (AW+1)'(len);
      bus.value = value;
      s = cyc + 1;
      push_fill(mode, base, len, value, s, pw0, pwl, dcyc);
      drive(s, dcyc, pw0, pwl, junk ? int'($urandom_range(1, dcyc - s)) : -1);
   endtask

`ifdef VRAM_FILL_BOOT_EN
   task automatic run_boot();
      int s;
      int dcyc;
      s = cyc + 1;
      push_fill(1, '0, 1 << AW, '0, s, 0, 0, dcyc);
      check("boot_done_rel", 64'(dcyc - s), 64'(2 * (1 << AW) + 1));
      drive(s, dcyc, 0, 0, int'($urandom_range(1, dcyc - s)));
   endtask
`endif

   initial begin
      int            s;
      int            dcyc;
      logic [AW-1:0] ab;
      bus.start = 1'b0;
      bus.mode  = '0;
      bus.base  = '0;
      bus.len   = '0;
      bus.value = '0;
      bus.pause = 1'b0;

      // Reset values.
      repeat (3) @(negedge MEMORY_CLK);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_cea", 64'(bus.v_cea), 64'd0);
      check("rst_ada", 64'(bus.v_ada), 64'd0);
      check("rst_din", 64'(bus.v_din), 64'd0);
      #1 rst_n = 1'b1;

`ifdef VRAM_FILL_BOOT_EN
      run_boot();
`else
      repeat (8) @(negedge MEMORY_CLK);
      check("idle_busy", 64'(bus.busy), 64'd0);
`endif

      // Directed cases.
      run_fill(0, 10'h3FE, 4, 8'hA5, 0, 0, 1'b0);   // CONST with address wrap
      run_fill(1, 10'h100, 3, 8'h7E, 0, 0, 1'b0);   // INC wraps through the mask
      run_fill(0, 10'h055, 0, 8'h11, 0, 0, 1'b0);   // zero length
      run_fill(0, 10'h020, 3, 8'h5A, 2, 5, 1'b0);   // pause after first write
      run_fill(2, 10'h3F0, 1 << AW, 8'hFF, 0, 0, 1'b1); // full region, ADDR pattern
      run_fill(3, 10'h3FF, 5, 8'hC3, 1, 3, 1'b1);   // mode 3 acts as CONST

      // Randomized fills with pause windows and ignored starts.
      for (int n = 0; n < 30; n++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 24));
         run_fill(int'($urandom_range(0, 3)), AW'($urandom), len, DW'($urandom),
                  int'($urandom_range(0, 2 * len + 2)), int'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)));
      end

      // Reset mid-fill: two writes land, then everything clears at once.
      ab = AW'($urandom_range(1, 10'h3F0));
      @(negedge MEMORY_CLK);
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      bus.base  = ab;
      bus.len   = (AW+1)'(8);
      bus.value = 8'h3C;
      s = cyc + 1;
      push_fill(0, ab, 8, 8'h3C, s, 0, 0, dcyc);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      void'(done_q.pop_back());
      @(negedge MEMORY_CLK);
      bus.start = 1'b0;
      for (int i = 0; i < 10 && (cyc + 1 < s + 4); i++) @(negedge MEMORY_CLK);
      #2 rst_n = 1'b0;
      #1;
      check("abort_writes_seen", 64'(exp_q.size()), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_cea", 64'(bus.v_cea), 64'd0);
      check("abort_ada", 64'(bus.v_ada), 64'd0);
      check("abort_din", 64'(bus.v_din), 64'd0);
      repeat (3) @(negedge MEMORY_CLK);
      #1 rst_n = 1'b1;
`ifdef VRAM_FILL_BOOT_EN
      run_boot();
`else
      repeat (20) @(negedge MEMORY_CLK);
      check("post_abort_busy", 64'(bus.busy), 64'd0);
`endif

      check("final_writes", 64'(exp_q.size()), 64'd0);
      check("final_done", 64'(done_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
